cache_requester: RTL and testbench



---
 rtl/cache_requester.sv | 233 +++++++++++++++++++++++
 tb/tb_cache_requester.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_requester.sv
// cache_requester: initiator side of the row-cache request interface.
// Queues row read / row write / sync requests in a small FIFO and replays them
// onto the RD/WR/sync/RowId interface with a minimum drive time, a fixed idle
// bubble between requests and hold back-pressure. Each completed request
// returns the cache slot (cRowId) sampled on its completion edge.
module cache_requester #(
  parameter int CHWIDTH   = 5,
  parameter int ADDRWIDTH = 17,
  parameter int DEPTH     = 4,
  parameter int MIN_CYC   = 3,
  parameter int GAP_CYC   = 1,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic                 req_sync,
  input  logic [ADDRWIDTH-1:0] req_row,
  output logic                 RD,
  output logic                 WR,
  output logic [ADDRWIDTH-1:0] RowId,
  output logic                 sync,
  input  logic                 hold,
  input  logic [CHWIDTH-1:0]   cRowId,
  output logic                 rsp_valid,
  output logic [CHWIDTH-1:0]   rsp_crow,
  output logic [ADDRWIDTH-1:0] rsp_row,
  output logic [1:0]           rsp_kind,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = ADDRWIDTH + 2;
  localparam int CW = $clog2(MIN_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int HW = $clog2(TIMEOUT + 1);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_CYC);
  localparam logic [GW-1:0] GAP_C    = GW'(GAP_CYC);
  localparam logic [HW-1:0] TO_C     = HW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  // ---------------------------------------------------------------------------
  // Request FIFO. Entry = {sync, wr, row}; sync entries carry wr = 0, row = 0
  // so the issue path can copy the head straight onto the interface.
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          empty, full, push, pop;
  logic [EW-1:0] head;
  logic          h_sync, h_wr;
  logic [ADDRWIDTH-1:0] h_row;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign req_ready = ~full;
  assign push      = req_valid & ~full;
  assign head      = mem_q[rptr_q];
  assign h_sync    = head[EW-1];
  assign h_wr      = head[EW-2];
  assign h_row     = head[ADDRWIDTH-1:0];

  // FIFO storage write; payload is not reset, only the pointers are
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {req_sync, req_wr & ~req_sync,
                                req_sync ? {ADDRWIDTH{1'b0}} : req_row};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;
  logic   load, done;

  logic                 rd_q, rd_d, wr_q, wr_d, sync_q, sync_d;
  logic [ADDRWIDTH-1:0] rowid_q, rowid_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [GW-1:0]        gcnt_q, gcnt_d;
  logic [HW-1:0]        hcnt_q, hcnt_d;
  logic                 err_q, err_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [CHWIDTH-1:0]   rsp_crow_q, rsp_crow_d;
  logic [ADDRWIDTH-1:0] rsp_row_q, rsp_row_d;
  logic [1:0]           rsp_kind_q, rsp_kind_d;

  assign pop = load;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: decide when to load the FIFO head and when a request completes
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          load    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if ((cnt_q >= MIN_C) && !hold) begin
          done    = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gcnt_q >= GAP_C) begin
          if (!empty) begin
            load    = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / counter next values; every interface output is registered below
  always_comb begin
    rd_d        = rd_q;
    wr_d        = wr_q;
    sync_d      = sync_q;
    rowid_d     = rowid_q;
    cnt_d       = cnt_q;
    gcnt_d      = gcnt_q;
    rsp_valid_d = 1'b0;
    rsp_crow_d  = rsp_crow_q;
    rsp_row_d   = rsp_row_q;
    rsp_kind_d  = rsp_kind_q;
    if (load) begin
      rd_d    = ~h_sync & ~h_wr;
      wr_d    = h_wr;
      sync_d  = h_sync;
      rowid_d = h_row;
      cnt_d   = CW'(1);
    end else if (done) begin
      rd_d        = 1'b0;
      wr_d        = 1'b0;
      sync_d      = 1'b0;
      rowid_d     = '0;
      rsp_valid_d = 1'b1;
      rsp_crow_d  = cRowId;
      rsp_row_d   = rowid_q;
      rsp_kind_d  = {sync_q, wr_q};
      gcnt_d      = GW'(1);
    end else if (state_q == S_ISSUE) begin
      if (cnt_q < MIN_C) cnt_d = cnt_q + 1'b1;
    end else if (state_q == S_GAP) begin
      if (gcnt_q < GAP_C) gcnt_d = gcnt_q + 1'b1;
    end

    // Consecutive stalled issue cycles; the flag is sticky until reset
    if ((state_q == S_ISSUE) && hold)
      hcnt_d = (hcnt_q == TO_C) ? hcnt_q : hcnt_q + 1'b1;
    else
      hcnt_d = '0;
    err_d = err_q | (hcnt_d == TO_C);
  end

  // Registered outputs and counters; reset drops any in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      sync_q      <= 1'b0;
      rowid_q     <= '0;
      cnt_q       <= '0;
      gcnt_q      <= '0;
      hcnt_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_crow_q  <= '0;
      rsp_row_q   <= '0;
      rsp_kind_q  <= '0;
    end else begin
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      sync_q      <= sync_d;
      rowid_q     <= rowid_d;
      cnt_q       <= cnt_d;
      gcnt_q      <= gcnt_d;
      hcnt_q      <= hcnt_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_crow_q  <= rsp_crow_d;
      rsp_row_q   <= rsp_row_d;
      rsp_kind_q  <= rsp_kind_d;
    end
  end

  assign RD          = rd_q;
  assign WR          = wr_q;
  assign sync        = sync_q;
  assign RowId       = rowid_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_crow    = rsp_crow_q;
  assign rsp_row     = rsp_row_q;
  assign rsp_kind    = rsp_kind_q;
  assign timeout_err = err_q;
  assign busy        = (state_q != S_IDLE) | ~empty;

endmodule

// File: tb/tb_cache_requester.sv
// Directed bench for cache_requester (default parameters).
// Inputs are driven and outputs sampled at the falling clock edge.
module tb_cache_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr, req_sync;
  logic [16:0] req_row;
  logic        RD, WR, sync;
  logic [16:0] RowId;
  logic        hold;
  logic [4:0]  cRowId;
  logic        rsp_valid;
  logic [4:0]  rsp_crow;
  logic [16:0] rsp_row;
  logic [1:0]  rsp_kind;
  logic        busy, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_requester dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_sync(req_sync), .req_row(req_row),
    .RD(RD), .WR(WR), .RowId(RowId), .sync(sync),
    .hold(hold), .cRowId(cRowId),
    .rsp_valid(rsp_valid), .rsp_crow(rsp_crow), .rsp_row(rsp_row),
    .rsp_kind(rsp_kind), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request for one cycle (caller is at a falling edge)
  task automatic push(input logic wr, input logic sy, input logic [16:0] row);
    chk("push_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wr = wr; req_sync = sy; req_row = row;
    @(negedge clk);
    req_valid = 1'b0; req_wr = 1'b0; req_sync = 1'b0; req_row = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    logic seen;
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_sync = 1'b0;
    req_row = '0; hold = 1'b0; cRowId = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_RD", {31'd0, RD}, 0);
    chk("rst_WR", {31'd0, WR}, 0);
    chk("rst_sync", {31'd0, sync}, 0);
    chk("rst_RowId", {15'd0, RowId}, 0);
    chk("rst_ready", {31'd0, req_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rspv", {31'd0, rsp_valid}, 0);
    chk("rst_err", {31'd0, timeout_err}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single write, row 150
    push(1'b1, 1'b0, 17'd150);
    chk("t1_pending_WR", {31'd0, WR}, 0);
    chk("t1_pending_busy", {31'd0, busy}, 1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("t1_WR", {31'd0, WR}, 1);
      chk("t1_RD", {31'd0, RD}, 0);
      chk("t1_RowId", {15'd0, RowId}, 150);
      if (i == 2) cRowId = 5'd9;
      @(negedge clk);
    end
    cRowId = 5'd0;
    chk("t1_done_WR", {31'd0, WR}, 0);
    chk("t1_done_RowId", {15'd0, RowId}, 0);
    chk("t1_rspv", {31'd0, rsp_valid}, 1);
    chk("t1_kind", {30'd0, rsp_kind}, 1);
    chk("t1_row", {15'd0, rsp_row}, 150);
    chk("t1_crow", {27'd0, rsp_crow}, 9);
    @(negedge clk);
    chk("t1_rspv_pulse", {31'd0, rsp_valid}, 0);
    chk("t1_idle_busy", {31'd0, busy}, 0);

    // Back-to-back write 590 then read 590
    cRowId = 5'd3;
    push(1'b1, 1'b0, 17'd590);
    push(1'b0, 1'b0, 17'd590);
    for (int i = 0; i < 3; i++) begin
      chk("t2_WR", {31'd0, WR}, 1);
      chk("t2_WR_row", {15'd0, RowId}, 590);
      @(negedge clk);
    end
    chk("t2_gap_WR", {31'd0, WR}, 0);
    chk("t2_gap_RD", {31'd0, RD}, 0);
    chk("t2_rsp1_v", {31'd0, rsp_valid}, 1);
    chk("t2_rsp1_kind", {30'd0, rsp_kind}, 1);
    chk("t2_rsp1_row", {15'd0, rsp_row}, 590);
    chk("t2_rsp1_crow", {27'd0, rsp_crow}, 3);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("t2_RD", {31'd0, RD}, 1);
      chk("t2_RD_WR", {31'd0, WR}, 0);
      chk("t2_RD_row", {15'd0, RowId}, 590);
      if (i == 0) chk("t2_rsp1_pulse", {31'd0, rsp_valid}, 0);
      @(negedge clk);
    end
    chk("t2_rsp2_v", {31'd0, rsp_valid}, 1);
    chk("t2_rsp2_kind", {30'd0, rsp_kind}, 0);
    chk("t2_rsp2_row", {15'd0, rsp_row}, 590);
    repeat (2) @(negedge clk);

    // Back-pressure: hold high during issue cycles 2..6
    push(1'b0, 1'b0, 17'd300);
    @(negedge clk);
    for (int k = 1; k <= 7; k++) begin
      chk("t3_RD", {31'd0, RD}, 1);
      chk("t3_RowId", {15'd0, RowId}, 300);
      chk("t3_no_rsp", {31'd0, rsp_valid}, 0);
      hold = (k >= 2 && k <= 6);
      @(negedge clk);
    end
    hold = 1'b0;
    chk("t3_RD_off", {31'd0, RD}, 0);
    chk("t3_rspv", {31'd0, rsp_valid}, 1);
    chk("t3_row", {15'd0, rsp_row}, 300);
    chk("t3_err", {31'd0, timeout_err}, 0);
    repeat (2) @(negedge clk);

    // FIFO full under hold
    hold = 1'b1;
    for (int k = 0; k < 5; k++) push(k[0], 1'b0, 17'(11 + k));
    chk("t4_ready_full", {31'd0, req_ready}, 0);
    chk("t4_busy", {31'd0, busy}, 1);
    chk("t4_RD_head", {31'd0, RD}, 1);
    chk("t4_RowId_head", {15'd0, RowId}, 11);
    @(negedge clk);
    chk("t4_ready_still_full", {31'd0, req_ready}, 0);
    hold = 1'b0;
    got = 0;
    for (int c = 0; c < 100 && got < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("t4_drain_row", {15'd0, rsp_row}, 32'(11 + got));
        chk("t4_drain_kind", {30'd0, rsp_kind}, {31'd0, got[0]});
        got++;
      end
    end
    chk("t4_drain_count", got, 5);
    chk("t4_ready_after", {31'd0, req_ready}, 1);
    chk("t4_err", {31'd0, timeout_err}, 0);
    repeat (3) @(negedge clk);
    chk("t4_idle_busy", {31'd0, busy}, 0);

    // Timeout: sync request stalled by hold
    cRowId = 5'd21;
    hold = 1'b1;
    push(1'b0, 1'b1, 17'd999);
    @(negedge clk);
    chk("t5_sync", {31'd0, sync}, 1);
    chk("t5_sync_RowId", {15'd0, RowId}, 0);
    repeat (58) @(negedge clk);
    chk("t5_err_early", {31'd0, timeout_err}, 0);
    repeat (10) @(negedge clk);
    chk("t5_err_set", {31'd0, timeout_err}, 1);
    chk("t5_sync_held", {31'd0, sync}, 1);
    chk("t5_RD_WR_low", {30'd0, RD, WR}, 0);
    hold = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("t5_kind", {30'd0, rsp_kind}, 2);
        chk("t5_row", {15'd0, rsp_row}, 0);
        chk("t5_crow", {27'd0, rsp_crow}, 21);
        got++;
      end
    end
    chk("t5_rsp_seen", got, 1);
    repeat (3) @(negedge clk);
    chk("t5_err_sticky", {31'd0, timeout_err}, 1);

    // Reset during the 2nd RD cycle
    push(1'b0, 1'b0, 17'd77);
    @(negedge clk);
    @(negedge clk);
    chk("t6_RD_before", {31'd0, RD}, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_RD", {31'd0, RD}, 0);
    chk("t6_async_RowId", {15'd0, RowId}, 0);
    chk("t6_async_WRsync", {30'd0, WR, sync}, 0);
    @(negedge clk);
    chk("t6_ready", {31'd0, req_ready}, 1);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_err_clr", {31'd0, timeout_err}, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      seen = seen | rsp_valid | RD;
    end
    chk("t6_no_rsp", {31'd0, seen}, 0);
    chk("t6_busy_after", {31'd0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
